fifo_rr_scheduler: RTL and testbench

Round-robin scheduler that drains four source FIFO instances into one destination FIFO, one word per cycle. It sits between the per-lane input FIFOs and the shared output FIFO of the switch datapath. It generates the `read`/`write` strobes, honours the destination's `fifo_pause` back-pressure, and owns the FIFOs' almost-full/almost-empty threshold configuration. It also aggregates their error flags.

---
 rtl/fifo_rr_scheduler.sv | 208 ++++++++++++++++++++
 tb/tb_fifo_rr_scheduler.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rr_scheduler.sv
// ---------------------------------------------------------------------------
// fifo_rr_scheduler
//
// Round-robin scheduler that drains four source FIFOs into one destination
// FIFO at up to one word per cycle. It issues the source read strobes and
// the destination write strobe, and it honours destination back-pressure.
// It also owns the almost-full/almost-empty thresholds shared by all five
// FIFOs, and it keeps a sticky OR of their error flags.
//
// Ports
//   clk             : clock; all state updates on the rising edge
//   reset_L         : asynchronous active-low reset
//   init            : configuration request; forces the INIT state
//   cfg_th_full     : almost-full threshold, sampled every INIT cycle
//   cfg_th_empty    : almost-empty threshold, sampled every INIT cycle
//   src_empty       : per-source fifo_empty
//   src_data        : per-source fifo_data_out, source i at [i*DATA_SIZE +: DATA_SIZE]
//   src_error       : per-source fifo_error
//   dst_pause       : destination fifo_pause (back-pressure)
//   dst_error       : destination fifo_error
//   src_read        : per-source read strobe, one-hot or zero
//   dst_write       : destination write strobe
//   dst_data        : destination data_in
//   th_almost_full  : almost-full threshold driven to all FIFOs
//   th_almost_empty : almost-empty threshold driven to all FIFOs
//   grant           : index of the source picked by the most recent read
//   idle            : high while in IDLE
//   error           : sticky OR of all FIFO error flags
// ---------------------------------------------------------------------------
module fifo_rr_scheduler #(
  parameter int DATA_SIZE = 12,
  parameter int NUM_SRC   = 4
) (
  input  logic                         clk,
  input  logic                         reset_L,
  input  logic                         init,
  input  logic [DATA_SIZE-1:0]         cfg_th_full,
  input  logic [DATA_SIZE-1:0]         cfg_th_empty,
  input  logic [NUM_SRC-1:0]           src_empty,
  input  logic [NUM_SRC*DATA_SIZE-1:0] src_data,
  input  logic [NUM_SRC-1:0]           src_error,
  input  logic                         dst_pause,
  input  logic                         dst_error,
  output logic [NUM_SRC-1:0]           src_read,
  output logic                         dst_write,
  output logic [DATA_SIZE-1:0]         dst_data,
  output logic [DATA_SIZE-1:0]         th_almost_full,
  output logic [DATA_SIZE-1:0]         th_almost_empty,
  output logic [1:0]                   grant,
  output logic                         idle,
  output logic                         error
);

  localparam int IDX_W = $clog2(NUM_SRC);

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_IDLE   = 2'd1,
    ST_ACTIVE = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     last_q, last_d;
  logic [IDX_W-1:0]     grant_q, grant_d;
  logic                 wr_q, wr_d;
  logic [DATA_SIZE-1:0] th_full_q, th_full_d;
  logic [DATA_SIZE-1:0] th_empty_q, th_empty_d;
  logic                 error_q, error_d;

  logic [IDX_W-1:0]     sel;
  logic                 found;
  logic [IDX_W-1:0]     idx;
  logic [DATA_SIZE-1:0] grant_word;

  // -------------------------------------------------------------------------
  // Round-robin pick: scan last+1, last+2, ... (mod NUM_SRC) and take the
  // first non-empty source. The pointer arithmetic wraps naturally in IDX_W
  // bits.
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before any conditional assignment,
    // so no path through the block leaves it unassigned and no latch appears.
    sel   = last_q;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      idx = last_q + IDX_W'(k);
      if (!found && !src_empty[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q <= ST_INIT;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every register
      // samples pre-edge values regardless of process evaluation order.
      state_q <= state_d;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next-state logic. init outranks everything else.
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT: begin
        if (!init) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (init)                state_d = ST_INIT;
        else if (!(&src_empty))  state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (init)                             state_d = ST_INIT;
        else if ((&src_empty) && !(|src_read)) state_d = ST_IDLE;
      end
      default: state_d = ST_INIT;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: outputs. The read strobe is combinational so a pick in cycle N pops
  // the source on the edge ending cycle N. A pause blocks the read in the
  // same cycle it is seen.
  // -------------------------------------------------------------------------
  always_comb begin
    src_read = '0;
    idle     = 1'b0;
    case (state_q)
      ST_IDLE:   idle = 1'b1;
      ST_ACTIVE: begin
        if (!init && !dst_pause && found) src_read[sel] = 1'b1;
      end
      default: ;
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath next-state: pointer/grant follow each read; thresholds track the
  // configuration inputs only while in INIT, which also clears the error.
  // -------------------------------------------------------------------------
  always_comb begin
    last_d     = last_q;
    grant_d    = grant_q;
    wr_d       = |src_read;
    th_full_d  = th_full_q;
    th_empty_d = th_empty_q;
    error_d    = error_q;

    if (|src_read) begin
      last_d  = sel;
      grant_d = sel;
    end

    if (state_q == ST_INIT) begin
      th_full_d  = cfg_th_full;
      th_empty_d = cfg_th_empty;
      error_d    = 1'b0;
    end else begin
      error_d = error_q | (|src_error) | dst_error;
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      last_q     <= IDX_W'(NUM_SRC - 1);
      grant_q    <= '0;
      wr_q       <= 1'b0;
      th_full_q  <= '0;
      th_empty_q <= '0;
      error_q    <= 1'b0;
    end else begin
      last_q     <= last_d;
      grant_q    <= grant_d;
      wr_q       <= wr_d;
      th_full_q  <= th_full_d;
      th_empty_q <= th_empty_d;
      error_q    <= error_d;
    end
  end

  // -------------------------------------------------------------------------
  // Output pipeline: the source presents the popped word one cycle after the
  // read edge, which is exactly when wr_q and grant_q describe that read.
  // -------------------------------------------------------------------------
  always_comb begin
    grant_word = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant_q == IDX_W'(i)) grant_word = src_data[i*DATA_SIZE +: DATA_SIZE];
    end
  end

  assign dst_write       = wr_q;
  assign dst_data        = wr_q ? grant_word : '0;
  assign th_almost_full  = th_full_q;
  assign th_almost_empty = th_empty_q;
  assign grant           = grant_q;
  assign error           = error_q;

endmodule

// File: tb/tb_fifo_rr_scheduler.sv
// ---------------------------------------------------------------------------
// tb_fifo_rr_scheduler
//
// Self-checking bench for fifo_rr_scheduler. A vector table exercises the
// arbitration and FSM with directly driven empty flags. After that, four
// behavioural source FIFOs feed the DUT, and every popped word is pushed to
// a scoreboard. Each word is compared when dst_write presents it.
// ---------------------------------------------------------------------------
module tb_fifo_rr_scheduler;

  localparam int DW = 12;
  localparam int NS = 4;

  logic              clk = 1'b0;
  logic              reset_L;
  logic              init;
  logic [DW-1:0]     cfg_th_full, cfg_th_empty;
  logic [NS-1:0]     src_empty;
  logic [NS*DW-1:0]  src_data;
  logic [NS-1:0]     src_error;
  logic              dst_pause, dst_error;
  logic [NS-1:0]     src_read;
  logic              dst_write;
  logic [DW-1:0]     dst_data;
  logic [DW-1:0]     th_almost_full, th_almost_empty;
  logic [1:0]        grant;
  logic              idle, error;

  always #5 clk = ~clk;

  fifo_rr_scheduler #(.DATA_SIZE(DW), .NUM_SRC(NS)) dut (
    .clk             (clk),
    .reset_L         (reset_L),
    .init            (init),
    .cfg_th_full     (cfg_th_full),
    .cfg_th_empty    (cfg_th_empty),
    .src_empty       (src_empty),
    .src_data        (src_data),
    .src_error       (src_error),
    .dst_pause       (dst_pause),
    .dst_error       (dst_error),
    .src_read        (src_read),
    .dst_write       (dst_write),
    .dst_data        (dst_data),
    .th_almost_full  (th_almost_full),
    .th_almost_empty (th_almost_empty),
    .grant           (grant),
    .idle            (idle),
    .error           (error)
  );

  typedef struct packed {
    logic       init;
    logic [3:0] empty;
    logic       pause;
    logic [3:0] exp_read;
    logic       exp_idle;
  } vec_t;

  typedef struct packed {
    logic [1:0]    src;
    logic [DW-1:0] data;
  } exp_t;

  vec_t          vecs [18];
  exp_t          exp_q [$];
  int            gq [$];
  logic [DW-1:0] mem [NS][16];
  int            head [NS];
  int            tail [NS];
  logic [DW-1:0] word_r [NS];
  logic [3:0]    sgl_pat [6];

  int         total = 0;
  int         bad   = 0;
  logic       use_model;
  logic [3:0] rd_s;
  logic       idle_s;
  int         wr_cnt = 0;
  int         cyc = 0;
  int         first_wr, last_wr, wr0;
  logic [3:0] prev_read;
  logic       found1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  function automatic int onehot_idx(input logic [3:0] v);
    for (int i = 0; i < NS; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Constant words presented by the sources during the vector table.
  function automatic logic [DW-1:0] tword(input int i);
    return DW'(12'h100 * (i + 1) + i);
  endfunction

  task automatic drive_src();
    for (int i = 0; i < NS; i++) begin
      src_empty[i]           = (head[i] == tail[i]);
      src_data[i*DW +: DW]   = word_r[i];
    end
  endtask

  task automatic push_src(input int s, input logic [DW-1:0] w);
    if (head[s] == tail[s]) begin
      head[s] = 0;
      tail[s] = 0;
    end
    mem[s][tail[s]] = w;
    tail[s]++;
    drive_src();
  endtask

  task automatic flush_src();
    for (int i = 0; i < NS; i++) begin
      head[i] = 0;
      tail[i] = 0;
    end
    drive_src();
  endtask

  // One clock: check outputs at the falling edge, then model the source pops
  // just after the rising edge.
  task automatic cycle();
    exp_t ex;
    int   g;
    @(negedge clk);
    cyc++;
    rd_s   = src_read;
    idle_s = idle;
    check("read_onehot", 32'($onehot0(src_read)), 32'd1);
    if (dst_write) begin
      wr_cnt++;
      if (first_wr < 0) first_wr = cyc;
      last_wr = cyc;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got data %0h, required no write", dst_data);
      end else begin
        ex = exp_q.pop_front();
        check("dst_data", 32'(dst_data), 32'(ex.data));
        check("grant", 32'(grant), 32'(ex.src));
      end
    end
    if (rd_s != 4'b0000 && gq.size() > 0) begin
      g = gq.pop_front();
      check("grant_order", onehot_idx(rd_s), g);
    end
    @(posedge clk);
    #1;
    if (use_model) begin
      for (int i = 0; i < NS; i++) begin
        if (rd_s[i]) begin
          if (head[i] == tail[i]) begin
            total++;
            bad++;
            $display("FAIL read_of_empty: source %0d read while empty, required no read", i);
          end else begin
            word_r[i] = mem[i][head[i]];
            head[i]++;
            ex.src  = 2'(i);
            ex.data = word_r[i];
            exp_q.push_back(ex);
          end
        end
      end
      drive_src();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // {init, empty, pause, exp_read, exp_idle}; row 0 starts in INIT with last = 3
    vecs[0]  = '{1'b0, 4'b1111, 1'b0, 4'b0000, 1'b0};
    vecs[1]  = '{1'b0, 4'b1111, 1'b0, 4'b0000, 1'b1};
    vecs[2]  = '{1'b0, 4'b1010, 1'b0, 4'b0000, 1'b1};
    vecs[3]  = '{1'b0, 4'b1010, 1'b0, 4'b0001, 1'b0};
    vecs[4]  = '{1'b0, 4'b1010, 1'b0, 4'b0100, 1'b0};
    vecs[5]  = '{1'b0, 4'b1010, 1'b0, 4'b0001, 1'b0};
    vecs[6]  = '{1'b0, 4'b1010, 1'b1, 4'b0000, 1'b0};
    vecs[7]  = '{1'b0, 4'b0000, 1'b0, 4'b0010, 1'b0};
    vecs[8]  = '{1'b0, 4'b0111, 1'b0, 4'b1000, 1'b0};
    vecs[9]  = '{1'b0, 4'b0111, 1'b0, 4'b1000, 1'b0};
    vecs[10] = '{1'b0, 4'b1111, 1'b0, 4'b0000, 1'b0};
    vecs[11] = '{1'b0, 4'b1111, 1'b0, 4'b0000, 1'b1};
    vecs[12] = '{1'b1, 4'b1110, 1'b0, 4'b0000, 1'b1};
    vecs[13] = '{1'b1, 4'b1110, 1'b0, 4'b0000, 1'b0};
    vecs[14] = '{1'b0, 4'b1110, 1'b0, 4'b0000, 1'b0};
    vecs[15] = '{1'b0, 4'b1110, 1'b0, 4'b0000, 1'b1};
    vecs[16] = '{1'b1, 4'b1110, 1'b0, 4'b0000, 1'b0};
    vecs[17] = '{1'b0, 4'b1110, 1'b0, 4'b0000, 1'b0};
    sgl_pat  = '{4'b0000, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000};

    // ---- reset state -------------------------------------------------------
    use_model    = 1'b0;
    reset_L      = 1'b0;
    init         = 1'b0;
    cfg_th_full  = '0;
    cfg_th_empty = '0;
    src_empty    = 4'hF;
    src_error    = '0;
    dst_pause    = 1'b0;
    dst_error    = 1'b0;
    first_wr     = -1;
    last_wr      = -1;
    for (int i = 0; i < NS; i++) begin
      head[i]   = 0;
      tail[i]   = 0;
      word_r[i] = '0;
    end
    for (int i = 0; i < NS; i++) src_data[i*DW +: DW] = tword(i);
    #2;
    check("rst_read", 32'(src_read), 0);
    check("rst_write", 32'(dst_write), 0);
    check("rst_data", 32'(dst_data), 0);
    check("rst_idle", 32'(idle), 0);
    check("rst_error", 32'(error), 0);
    check("rst_grant", 32'(grant), 0);
    check("rst_th_full", 32'(th_almost_full), 0);
    check("rst_th_empty", 32'(th_almost_empty), 0);
    @(posedge clk);
    #1;
    reset_L = 1'b1;

    // ---- vector table ------------------------------------------------------
    prev_read = 4'b0000;
    for (int r = 0; r < 18; r++) begin
      init      = vecs[r].init;
      src_empty = vecs[r].empty;
      dst_pause = vecs[r].pause;
      @(negedge clk);
      check($sformatf("vec%0d_read", r), 32'(src_read), 32'(vecs[r].exp_read));
      check($sformatf("vec%0d_idle", r), 32'(idle), 32'(vecs[r].exp_idle));
      check($sformatf("vec%0d_write", r), 32'(dst_write), 32'(prev_read != 4'b0000));
      if (prev_read != 4'b0000)
        check($sformatf("vec%0d_data", r), 32'(dst_data), 32'(tword(onehot_idx(prev_read))));
      prev_read = vecs[r].exp_read;
      @(posedge clk);
      #1;
    end

    // ---- switch to behavioural sources ------------------------------------
    init      = 1'b0;
    dst_pause = 1'b0;
    use_model = 1'b1;
    drive_src();

    // ---- configuration -----------------------------------------------------
    cfg_th_full  = 12'd6;
    cfg_th_empty = 12'd2;
    init = 1'b1;
    cycle();
    cycle();
    init = 1'b0;
    cycle();
    check("cfg_full", 32'(th_almost_full), 6);
    check("cfg_empty", 32'(th_almost_empty), 2);
    cfg_th_full  = 12'd9;
    cfg_th_empty = 12'd9;
    repeat (3) cycle();
    check("cfg_full_hold", 32'(th_almost_full), 6);
    check("cfg_empty_hold", 32'(th_almost_empty), 2);
    check("cfg_idle", 32'(idle), 1);

    // ---- error aggregation -------------------------------------------------
    src_error = 4'b1000;
    cycle();
    src_error = 4'b0000;
    check("err_set", 32'(error), 1);
    cycle();
    cycle();
    check("err_sticky", 32'(error), 1);
    init = 1'b1;
    cycle();
    init = 1'b0;
    cycle();
    check("err_clear", 32'(error), 0);
    dst_error = 1'b1;
    cycle();
    dst_error = 1'b0;
    check("err_dst_set", 32'(error), 1);
    init = 1'b1;
    cycle();
    init = 1'b0;
    cycle();
    check("err_dst_clear", 32'(error), 0);

    // ---- single source, back-to-back --------------------------------------
    push_src(2, 12'hA01);
    push_src(2, 12'hA02);
    push_src(2, 12'hA03);
    wr0 = wr_cnt;
    for (int k = 0; k < 6; k++) begin
      cycle();
      check($sformatf("single_rd%0d", k), 32'(rd_s), 32'(sgl_pat[k]));
    end
    check("single_writes", wr_cnt - wr0, 3);
    check("single_idle", 32'(idle_s), 1);
    check("single_sb_empty", exp_q.size(), 0);

    // ---- asynchronous reset mid-stream ------------------------------------
    push_src(0, 12'hC01);
    push_src(0, 12'hC02);
    push_src(0, 12'hC03);
    dst_error = 1'b1;
    cycle();
    dst_error = 1'b0;
    cycle();
    cycle();
    check("pre_rst_write", 32'(dst_write), 1);
    check("pre_rst_error", 32'(error), 1);
    #3;
    reset_L = 1'b0;
    #1;
    check("mid_rst_read", 32'(src_read), 0);
    check("mid_rst_write", 32'(dst_write), 0);
    check("mid_rst_data", 32'(dst_data), 0);
    check("mid_rst_grant", 32'(grant), 0);
    check("mid_rst_idle", 32'(idle), 0);
    check("mid_rst_error", 32'(error), 0);
    check("mid_rst_th_full", 32'(th_almost_full), 0);
    check("mid_rst_th_empty", 32'(th_almost_empty), 0);
    exp_q.delete();
    gq.delete();
    flush_src();
    @(posedge clk);
    #1;
    reset_L = 1'b1;
    cycle();
    check("post_rst_init_idle", 32'(idle_s), 0);
    check("post_rst_idle", 32'(idle), 1);

    // ---- contention: all four sources, two words each ----------------------
    for (int k = 0; k < 2; k++)
      for (int s = 0; s < NS; s++) push_src(s, DW'(12'hB00 + s * 16 + k));
    for (int k = 0; k < 8; k++) gq.push_back(k % NS);
    wr0      = wr_cnt;
    first_wr = -1;
    repeat (12) cycle();
    check("cont_writes", wr_cnt - wr0, 8);
    check("cont_back_to_back", last_wr - first_wr, 7);
    check("cont_grants_seen", gq.size(), 0);
    check("cont_sb_empty", exp_q.size(), 0);
    check("cont_idle", 32'(idle), 1);

    // ---- back-pressure -----------------------------------------------------
    for (int k = 0; k < 2; k++)
      for (int s = 0; s < NS; s++) push_src(s, DW'(12'hD00 + s * 16 + k));
    found1 = 1'b0;
    for (int k = 0; k < 20; k++) begin
      cycle();
      if (rd_s[1]) begin
        found1 = 1'b1;
        break;
      end
    end
    check("bp_saw_src1", 32'(found1), 1);
    dst_pause = 1'b1;
    wr0 = wr_cnt;
    for (int k = 0; k < 4; k++) begin
      cycle();
      check($sformatf("bp_no_read%0d", k), 32'(rd_s), 0);
    end
    check("bp_one_write", wr_cnt - wr0, 1);
    dst_pause = 1'b0;
    gq.push_back(2);
    cycle();
    check("bp_resume_src2", 32'(rd_s), 32'(4'b0100));
    repeat (12) cycle();
    check("bp_sb_empty", exp_q.size(), 0);
    check("bp_idle", 32'(idle), 1);
    for (int s = 0; s < NS; s++)
      check($sformatf("bp_src%0d_drained", s), tail[s] - head[s], 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
